// File: rtl/clk_gen_pkg.sv
// Shared parameters and types for the multi-channel clock-enable generator.
// Request fields are sized for the widest supported build: up to 256 channels, 32-bit ratios.
package clk_gen_pkg;

   localparam int          DIV_W_DEF       = 26;
   localparam int unsigned DEFAULT_DIV_DEF = 25_000_000;

   localparam int CFG_CH_W  = 8;
   localparam int CFG_DIV_W = 32;

   typedef struct packed {
      logic [CFG_CH_W-1:0]  ch;
      logic [CFG_DIV_W-1:0] div;
   } cfg_req_t;

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counts 0..div-1, emits a one-cycle tick on terminal count and
// toggles clk_out. A new ratio is only taken at a period boundary so clk_out never glitches.
module clk_div_channel
   import clk_gen_pkg::*;
#(
   parameter int          DIV_W       = DIV_W_DEF,
   parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
   input  logic             clk_signal,
   input  logic             reset,
   input  logic             run_en,
   input  logic             sync_restart,
   input  logic             apply_req,
   input  logic [DIV_W-1:0] apply_div,
   output logic             boundary,
   output logic             tick,
   output logic             clk_out
);

   localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div;
   logic             running;
   logic             term;

   assign running  = run_en && (div != '0);
   assign term     = running && (cnt == div - ONE);
   // Any edge where the current period ends or never started is a safe point to swap the ratio.
   assign boundary = sync_restart || !running || term;

   always_ff @(posedge clk_signal) begin
      if (reset) begin
         cnt     <= '0;
         div     <= DIV_W'(DEFAULT_DIV);
         tick    <= 1'b0;
         clk_out <= 1'b0;
      end else begin
         if (apply_req && boundary)
            div <= apply_div;

         if (sync_restart) begin
            cnt     <= '0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
         end else if (!running) begin
            cnt  <= '0;
            tick <= 1'b0;
         end else if (term) begin
            cnt     <= '0;
            tick    <= 1'b1;
            clk_out <= ~clk_out;
         end else begin
            cnt  <= cnt + ONE;
            tick <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator: a single pending ratio-update slot with a
// valid/ready handshake, the sync_restart fan-out, and NUM_CH divider channels.
module clk_enable_gen
   import clk_gen_pkg::*;
#(
   parameter  int          NUM_CH      = 4,
   parameter  int          DIV_W       = DIV_W_DEF,
   parameter  int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF,
   localparam int          CH_W        = ch_width(NUM_CH)
) (
   input  logic              clk_signal,
   input  logic              reset,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              sync_restart,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] clk_out
);

   cfg_req_t          req;
   cfg_req_t          pend;
   logic              pend_valid;
   logic [NUM_CH-1:0] apply_sel;
   logic [NUM_CH-1:0] boundary;
   logic              pend_hit;
   logic              pend_miss;
   logic              unused_pend_div;

   always_comb begin
      req     = '0;
      req.ch  = CFG_CH_W'(cfg_ch);
      req.div = CFG_DIV_W'(cfg_div);
   end

   always_comb begin
      apply_sel = '0;
      for (int i = 0; i < NUM_CH; i++)
         apply_sel[i] = pend_valid && (pend.ch == CFG_CH_W'(i));
   end

   assign pend_hit  = |(apply_sel & boundary);
   // No channel matches: the index is out of range, so the update is simply dropped.
   assign pend_miss = pend_valid && !(|apply_sel);

   assign unused_pend_div = ^pend.div;

   always_ff @(posedge clk_signal) begin
      if (reset) begin
         pend_valid <= 1'b0;
         pend       <= '0;
         cfg_ready  <= 1'b0;
      end else if (cfg_valid && cfg_ready) begin
         pend_valid <= 1'b1;
         pend       <= req;
         cfg_ready  <= 1'b0;
      end else if (pend_hit || pend_miss) begin
         pend_valid <= 1'b0;
         cfg_ready  <= 1'b1;
      end else begin
         cfg_ready  <= !pend_valid;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clk_div_channel #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk_signal   (clk_signal),
         .reset        (reset),
         .run_en       (ch_en[g]),
         .sync_restart (sync_restart),
         .apply_req    (apply_sel[g]),
         .apply_div    (pend.div[DIV_W-1:0]),
         .boundary     (boundary[g]),
         .tick         (tick[g]),
         .clk_out      (clk_out[g])
      );
   end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Bench for clk_enable_gen: a timestamp-based reference model checked every cycle,
// directed scenarios with hand-computed expectations, then randomized traffic.
module tb_clk_enable_gen;

   // Five channels give a 3-bit index, so indices 5..7 exercise the out-of-range path.
   localparam int NUM_CH  = 5;
   localparam int DIV_W   = 8;
   localparam int DEF_DIV = 4;
   localparam int CH_W    = 3;

   logic              clk_signal   = 1'b0;
   logic              reset        = 1'b1;
   logic [NUM_CH-1:0] ch_en        = '0;
   logic              sync_restart = 1'b0;
   logic              cfg_valid    = 1'b0;
   logic [CH_W-1:0]   cfg_ch       = '0;
   logic [DIV_W-1:0]  cfg_div      = '0;
   logic              cfg_ready;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] clk_out;

   int errors = 0;
   int checks = 0;
   bit check_en = 1'b0;

   always #5 clk_signal = ~clk_signal;

   clk_enable_gen #(
      .NUM_CH      (NUM_CH),
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEF_DIV)
   ) dut (
      .clk_signal   (clk_signal),
      .reset        (reset),
      .ch_en        (ch_en),
      .sync_restart (sync_restart),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_ch       (cfg_ch),
      .cfg_div      (cfg_div),
      .tick         (tick),
      .clk_out      (clk_out)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: each channel keeps the absolute edge number of its next tick.
   int               m_div [NUM_CH];
   longint           m_due [NUM_CH];
   logic [NUM_CH-1:0] m_tick = '0;
   logic [NUM_CH-1:0] m_out  = '0;
   logic             m_ready = 1'b0;
   bit               m_pend  = 1'b0;
   int               m_pch   = 0;
   int               m_pdiv  = 0;
   longint           n       = 0;

   always @(posedge clk_signal) begin
      bit acc, done, run, term, bnd;
      n++;
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            m_div[i] = DEF_DIV;
            m_due[i] = n + DEF_DIV;
         end
         m_tick  = '0;
         m_out   = '0;
         m_pend  = 1'b0;
         m_ready = 1'b0;
      end else begin
         acc  = cfg_valid && m_ready;
         done = 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            run  = ch_en[i] && (m_div[i] != 0);
            term = run && (n == m_due[i]);
            bnd  = sync_restart || !run || term;
            if (m_pend && m_pch == i && bnd) begin
               m_div[i] = m_pdiv;
               done     = 1'b1;
            end
            m_tick[i] = term && !sync_restart;
            if (sync_restart)
               m_out[i] = 1'b0;
            else if (term)
               m_out[i] = ~m_out[i];
            if (bnd)
               m_due[i] = n + m_div[i];
         end
         if (m_pend && m_pch >= NUM_CH)
            done = 1'b1;
         if (acc) begin
            m_pend  = 1'b1;
            m_pch   = int'(cfg_ch);
            m_pdiv  = int'(cfg_div);
            m_ready = 1'b0;
         end else if (done) begin
            m_pend  = 1'b0;
            m_ready = 1'b1;
         end else begin
            m_ready = !m_pend;
         end
      end
   end

   always @(negedge clk_signal) begin
      if (check_en) begin
         chk("tick", 32'(tick), 32'(m_tick));
         chk("clk_out", 32'(clk_out), 32'(m_out));
         chk("cfg_ready", 32'(cfg_ready), 32'(m_ready));
      end
   end

   task automatic cyc(input int k = 1);
      repeat (k) begin
         @(posedge clk_signal);
         #1;
      end
   endtask

   task automatic wait_tick0(input string name);
      int k = 0;
      do begin
         cyc();
         k++;
      end while (!tick[0] && k < 50);
      chk(name, 32'(tick[0]), 32'd1);
   endtask

   task automatic send_cfg(input int ch, input int dv);
      bit acc = 1'b0;
      int k   = 0;
      cfg_valid = 1'b1;
      cfg_ch    = CH_W'(ch);
      cfg_div   = DIV_W'(dv);
      while (!acc && k < 100) begin
         acc = cfg_ready;
         cyc();
         k++;
      end
      cfg_valid = 1'b0;
      k = 0;
      while (!cfg_ready && k < 100) begin
         cyc();
         k++;
      end
      chk("cfg_done", 32'(cfg_ready), 32'd1);
   endtask

   initial begin
      int first, first1, ntk, other;
      logic [3:0] pat;

      // Reset state
      reset = 1'b1;
      cyc();
      check_en = 1'b1;
      cyc();
      chk("rst_tick", 32'(tick), 32'd0);
      chk("rst_clk_out", 32'(clk_out), 32'd0);
      chk("rst_ready", 32'(cfg_ready), 32'd0);

      // Channel 0 alone at the default ratio of 4
      reset = 1'b0;
      ch_en = 5'b00001;
      first = -1; ntk = 0; other = 0;
      for (int k = 1; k <= 12; k++) begin
         cyc();
         if (tick[0] && first < 0) first = k;
         ntk   += int'(tick[0]);
         other |= int'(tick[4:1]) | int'(clk_out[4:1]);
      end
      chk("first_tick", 32'(first), 32'd4);
      chk("tick_count", 32'(ntk), 32'd3);
      chk("clk0_level", 32'(clk_out[0]), 32'd1);
      chk("others_silent", 32'(other), 32'd0);

      // Retarget channel 0 to div 2 while cnt=1
      cyc();
      cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd2;
      cyc();
      cfg_valid = 1'b0;
      chk("cfg0_ready_a", 32'(cfg_ready), 32'd0);
      cyc();
      chk("cfg0_ready_b", 32'(cfg_ready), 32'd0);
      cyc();
      chk("cfg0_ready_apply", 32'(cfg_ready), 32'd1);
      chk("cfg0_apply_tick", 32'(tick[0]), 32'd1);
      pat = '0;
      for (int k = 0; k < 4; k++) begin
         cyc();
         pat = {pat[2:0], tick[0]};
      end
      chk("div2_pattern", 32'(pat), 32'h5);

      // Channel 2: toggle once, stop, program div 0, re-enable
      ch_en = 5'b00101;
      cyc(4);
      chk("ch2_toggle", 32'(clk_out[2]), 32'd1);
      ch_en = 5'b00001;
      cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 8'd0;
      cyc();
      cfg_valid = 1'b0;
      chk("cfg2_accept", 32'(cfg_ready), 32'd0);
      cyc();
      chk("cfg2_apply", 32'(cfg_ready), 32'd1);
      ch_en = 5'b00101;
      ntk = 0;
      for (int k = 0; k < 10; k++) begin
         cyc();
         ntk += int'(tick[2]);
      end
      chk("ch2_no_tick", 32'(ntk), 32'd0);
      chk("ch2_hold", 32'(clk_out[2]), 32'd1);

      // Channels 0/1 at 3/5, sync_restart on a channel-0 terminal count
      send_cfg(0, 3);
      send_cfg(1, 5);
      ch_en = 5'b00111;
      wait_tick0("wait_tick_pre_sync");
      cyc(2);
      sync_restart = 1'b1;
      cyc();
      sync_restart = 1'b0;
      chk("sync_no_tick", 32'(tick[1:0]), 32'd0);
      chk("sync_clk_low", 32'(clk_out[1:0]), 32'd0);
      first = -1; first1 = -1;
      for (int k = 1; k <= 6; k++) begin
         cyc();
         if (tick[0] && first < 0) first = k;
         if (tick[1] && first1 < 0) first1 = k;
      end
      chk("sync_first_tick0", 32'(first), 32'd3);
      chk("sync_first_tick1", 32'(first1), 32'd5);

      // Out-of-range channel index
      cfg_valid = 1'b1; cfg_ch = 3'd5; cfg_div = 8'd7;
      cyc();
      cfg_valid = 1'b0;
      chk("cfg5_accept", 32'(cfg_ready), 32'd0);
      cyc();
      chk("cfg5_discard", 32'(cfg_ready), 32'd1);

      // Reset mid-period with an update pending
      wait_tick0("wait_tick_pre_reset");
      cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd7;
      cyc();
      cfg_valid = 1'b0;
      reset = 1'b1;
      cyc();
      chk("mid_rst_tick", 32'(tick), 32'd0);
      chk("mid_rst_clk_out", 32'(clk_out), 32'd0);
      chk("mid_rst_ready", 32'(cfg_ready), 32'd0);
      reset = 1'b0;
      ch_en = 5'b00001;
      first = -1;
      for (int k = 1; k <= 8; k++) begin
         cyc();
         if (k == 1) chk("post_rst_ready", 32'(cfg_ready), 32'd1);
         if (tick[0] && first < 0) first = k;
      end
      chk("post_rst_first_tick", 32'(first), 32'd4);

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         bit r;
         bit rs;
         r = cfg_ready;
         if ($urandom_range(0, 15) == 0) ch_en = NUM_CH'($urandom | $urandom);
         sync_restart = ($urandom_range(0, 60) == 0);
         reset        = ($urandom_range(0, 400) == 0);
         rs = reset;
         if (!cfg_valid && $urandom_range(0, 5) == 0) begin
            cfg_valid = 1'b1;
            cfg_ch    = CH_W'($urandom_range(0, 7));
            cfg_div   = DIV_W'($urandom_range(0, 9));
         end
         cyc();
         if (cfg_valid && r && !rs) cfg_valid = 1'b0;
      end
      reset = 1'b0;
      sync_restart = 1'b0;
      cyc(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
